// File: rtl/psram_resp.sv
// Octal-DDR PSRAM responder: oversamples CE/SCK/IO/DQS on clk_i and turns the
// command/address/data beat stream into byte accesses on a simple memory port.
module psram_resp #(
  parameter int ADDR_W = 24  // supported range 17..32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [7:0]        cfg_rcmd_i,
  input  logic [7:0]        cfg_wcmd_i,
  input  logic [7:0]        cfg_rlc_i,
  input  logic [7:0]        cfg_wlc_i,
  input  logic              psram_sck_i,
  input  logic              psram_ce_i,
  input  logic [7:0]        psram_io_in_i,
  output logic [7:0]        psram_io_out_o,
  output logic              psram_io_en_o,
  input  logic              psram_dqs_in_i,
  output logic              psram_dqs_out_o,
  output logic              psram_dqs_en_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              cmd_err_o
);

  typedef enum logic [2:0] {IDLE, INST, ADDR, LATN, WDATA, RDATA, SKIP} state_t;

  state_t              state_q, state_d;
  logic                sck_q, sck_qq, ce_q, ce_qq, dqs_q, dqs_qq;
  logic [7:0]          io_q, io_qq;
  logic [1:0]          bcnt_q, bcnt_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-9:0]   ash_q, ash_d;
  logic [7:0]          lat_q, lat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, maddr_q, maddr_d;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [7:0]          wdata_q, wdata_d, io_out_q, io_out_d;
  logic                dqs_out_q, dqs_out_d, err_q, err_d;
  logic                rvld_q;
  logic [7:0]          pre_q;

  logic                sck_edge, sck_rise, ce_fall, ce_rise;
  logic [ADDR_W-1:0]   addr_full;
  logic [7:0]          pre_byte, lat_sel;

  assign sck_edge  = sck_q ^ sck_qq;
  assign sck_rise  = sck_q & ~sck_qq;
  assign ce_fall   = ce_qq & ~ce_q;
  assign ce_rise   = ce_q & ~ce_qq;
  assign addr_full = {ash_q, io_qq};
  // A read issued on the previous edge may only just be returning: bypass it.
  assign pre_byte  = rvld_q ? mem_rdata_i : pre_q;
  assign lat_sel   = rd_q ? cfg_rlc_i : cfg_wlc_i;

  // Sync stages reset to 0 so a CE held low through reset is not seen as a fall.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_q <= 1'b0; sck_qq <= 1'b0;
      ce_q  <= 1'b0; ce_qq  <= 1'b0;
      dqs_q <= 1'b0; dqs_qq <= 1'b0;
      io_q  <= '0;   io_qq  <= '0;
      rvld_q <= 1'b0; pre_q <= '0;
    end else begin
      sck_q <= psram_sck_i;    sck_qq <= sck_q;
      ce_q  <= psram_ce_i;     ce_qq  <= ce_q;
      dqs_q <= psram_dqs_in_i; dqs_qq <= dqs_q;
      io_q  <= psram_io_in_i;  io_qq  <= io_q;
      rvld_q <= mem_en_q & ~mem_we_q;
      if (rvld_q) pre_q <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      rd_q      <= 1'b0;
      ash_q     <= '0;
      lat_q     <= '0;
      addr_q    <= '0;
      maddr_q   <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      wdata_q   <= '0;
      io_out_q  <= '0;
      dqs_out_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      rd_q      <= rd_d;
      ash_q     <= ash_d;
      lat_q     <= lat_d;
      addr_q    <= addr_d;
      maddr_q   <= maddr_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      wdata_q   <= wdata_d;
      io_out_q  <= io_out_d;
      dqs_out_q <= dqs_out_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    rd_d      = rd_q;
    ash_d     = ash_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    maddr_d   = maddr_q;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    wdata_d   = wdata_q;
    io_out_d  = io_out_q;
    dqs_out_d = dqs_out_q;
    err_d     = 1'b0;
    if (ce_rise) begin
      state_d   = IDLE;
      maddr_d   = '0;
      wdata_d   = '0;
      io_out_d  = '0;
      dqs_out_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (ce_fall) begin
          state_d = INST;
          bcnt_d  = '0;
        end
        INST: if (sck_edge) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd1) begin
            bcnt_d = '0;
            if (io_qq == cfg_rcmd_i) begin
              state_d = ADDR; rd_d = 1'b1;
            end else if (io_qq == cfg_wcmd_i) begin
              state_d = ADDR; rd_d = 1'b0;
            end else begin
              state_d = SKIP; err_d = 1'b1;
            end
          end
        end
        ADDR: if (sck_edge) begin
          ash_d  = {ash_q[ADDR_W-17:0], io_qq};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            addr_d = addr_full;
            lat_d  = lat_sel;
            if (rd_q) begin
              mem_en_d = 1'b1;
              maddr_d  = addr_full;
            end
            if (lat_sel == 8'd0) begin
              state_d   = rd_q ? RDATA : WDATA;
              dqs_out_d = 1'b0;
            end else begin
              state_d = LATN;
            end
          end
        end
        LATN: if (sck_rise) begin
          lat_d = lat_q - 8'd1;
          if (lat_q == 8'd1) begin
            state_d   = rd_q ? RDATA : WDATA;
            dqs_out_d = 1'b0;
          end
        end
        WDATA: if (sck_edge) begin
          addr_d = addr_q + ADDR_W'(1);
          if (dqs_qq) begin
            mem_en_d = 1'b1;
            mem_we_d = 1'b1;
            maddr_d  = addr_q;
            wdata_d  = io_qq;
          end
        end
        RDATA: if (sck_edge) begin
          io_out_d  = pre_byte;
          dqs_out_d = ~dqs_out_q;
          addr_d    = addr_q + ADDR_W'(1);
          mem_en_d  = 1'b1;
          maddr_d   = addr_q + ADDR_W'(1);
        end
        SKIP: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign psram_io_out_o  = io_out_q;
  assign psram_io_en_o   = (state_q == RDATA);
  assign psram_dqs_out_o = dqs_out_q;
  assign psram_dqs_en_o  = (state_q == RDATA);
  assign mem_en_o        = mem_en_q;
  assign mem_we_o        = mem_we_q;
  assign mem_addr_o      = maddr_q;
  assign mem_wdata_o     = wdata_q;
  assign busy_o          = (state_q != IDLE);
  assign cmd_err_o       = err_q;

endmodule
